// File: rtl/corefifo_wr_pkg.sv
// Shared definitions for the corefifo write-side skid buffer:
// occupancy state encoding and the overflow counter width.
package corefifo_wr_pkg;

  // Occupancy of the two-entry skid buffer (head + skid registers)
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } wr_state_t;

  // Width of the optional saturating overflow counter
  localparam int OVF_CNT_W = 16;

endpackage : corefifo_wr_pkg

// File: rtl/corefifo_wr_skid.sv
// corefifo_wr_skid: two-entry write-side skid buffer in front of a FIFO
// controller. The user-facing full flag comes straight from the state
// register, so it never has a combinational path from wr_en, din or
// fifo_full; the second (skid) entry absorbs the one word that may be
// accepted in the cycle fifo_full rises.
// Optional feature: define COREFIFO_WR_OVF_CNT_EN to add the 16-bit
// saturating ovf_count output.
module corefifo_wr_skid
  import corefifo_wr_pkg::*;
#(
  parameter int WWIDTH    = 18,
  parameter int WRITE_LOW = 1,
  parameter int WCLK_HIGH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [WWIDTH-1:0] din,
  output logic              full,
  output logic              afull,
  output logic              overflow,
  output logic              fifo_wr_en,
  output logic [WWIDTH-1:0] fifo_din,
  input  logic              fifo_full,
  input  logic              fifo_afull
`ifdef COREFIFO_WR_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

  wr_state_t         r_state;
  wr_state_t         w_state_next;
  logic [WWIDTH-1:0] r_head;
  logic [WWIDTH-1:0] r_skid;
  logic [WWIDTH-1:0] w_head_next;
  logic [WWIDTH-1:0] w_skid_next;
  logic              r_overflow;
  logic              w_we_p;
  logic              w_accept;
  logic              w_drain;
  logic              w_clk;

  // Active clock edge selection: falling-edge builds register on inverted clk
  assign w_clk = (WCLK_HIGH != 0) ? clk : ~clk;

  // Write request in positive polarity and handshake terms
  assign w_we_p   = (WRITE_LOW != 0) ? ~wr_en : wr_en;
  assign full     = (r_state == ST_TWO);
  assign w_accept = w_we_p & ~full;
  assign w_drain  = (r_state != ST_EMPTY) & ~fifo_full;

  assign afull      = full | fifo_afull;
  assign fifo_wr_en = w_drain;
  assign fifo_din   = r_head;
  assign overflow   = r_overflow;

  // Next-state and storage steering for the two-entry buffer
  always_comb begin
    w_state_next = r_state;
    w_head_next  = r_head;
    w_skid_next  = r_skid;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_next = ST_ONE;
          w_head_next  = din;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_head_next = din;
        end else if (w_accept) begin
          w_state_next = ST_TWO;
          w_skid_next  = din;
        end else if (w_drain) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // Never accepts here; skid moves forward once head has drained
        if (w_drain) begin
          w_state_next = ST_ONE;
          w_head_next  = r_skid;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  // State, storage and overflow pulse registers; reset wins over everything
  always_ff @(posedge w_clk) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_head     <= '0;
      r_skid     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_head     <= w_head_next;
      r_skid     <= w_skid_next;
      r_overflow <= w_we_p & full;
    end
  end

`ifdef COREFIFO_WR_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] r_ovf_count;

  // Count overflow pulses, holding at all-ones instead of wrapping
  always_ff @(posedge w_clk) begin
    if (reset) begin
      r_ovf_count <= '0;
    end else if (r_overflow && (r_ovf_count != {OVF_CNT_W{1'b1}})) begin
      r_ovf_count <= r_ovf_count + 1'b1;
    end
  end

  assign ovf_count = r_ovf_count;
`endif

endmodule : corefifo_wr_skid

// File: tb/tb_corefifo_wr_skid.sv
// Self-checking bench for corefifo_wr_skid: directed steps on the default
// (active-low wr_en) instance, a constrained-random run against a small
// occupancy/queue model, and an active-high wr_en instance.
// Checks ovf_count when COREFIFO_WR_OVF_CNT_EN is defined.
module tb_corefifo_wr_skid;
  localparam int W = 18;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [W-1:0]  din;
  logic          fifo_full;
  logic          fifo_afull;
  logic          full, afull, overflow, fifo_wr_en;
  logic [W-1:0]  fifo_din;
`ifdef COREFIFO_WR_OVF_CNT_EN
  logic [15:0]   ovf_count;
  logic [15:0]   h_ovf_count;
`endif

  logic          h_wr_en;
  logic [W-1:0]  h_din;
  logic          h_full, h_afull, h_overflow, h_fifo_wr_en;
  logic [W-1:0]  h_fifo_din;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  corefifo_wr_skid #(.WWIDTH(W), .WRITE_LOW(1), .WCLK_HIGH(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .din(din),
    .full(full), .afull(afull), .overflow(overflow),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
    .fifo_full(fifo_full), .fifo_afull(fifo_afull)
`ifdef COREFIFO_WR_OVF_CNT_EN
    , .ovf_count(ovf_count)
`endif
  );

  corefifo_wr_skid #(.WWIDTH(W), .WRITE_LOW(0), .WCLK_HIGH(1)) dut_hi (
    .clk(clk), .reset(reset), .wr_en(h_wr_en), .din(h_din),
    .full(h_full), .afull(h_afull), .overflow(h_overflow),
    .fifo_wr_en(h_fifo_wr_en), .fifo_din(h_fifo_din),
    .fifo_full(1'b0), .fifo_afull(1'b0)
`ifdef COREFIFO_WR_OVF_CNT_EN
    , .ovf_count(h_ovf_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Logical write request (1 = write); the default instance is active-low
  task automatic drive(input logic we, input logic [W-1:0] d, input logic ff);
    wr_en     = ~we;
    din       = d;
    fifo_full = ff;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int          cnt;
    int          rejected;
    int          ovf_seen;
    logic        ovf_exp;
    logic [W-1:0] q[$];
    logic        we, ff, full_exp, drain_exp;
    logic [W-1:0] d;

    reset = 1'b1; wr_en = 1'b1; din = '0; fifo_full = 1'b0; fifo_afull = 1'b0;
    h_wr_en = 1'b0; h_din = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    check("rst_full", full, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_ovf", overflow, 0);
    check("rst_afull", afull, 0);
    check("rst_din", fifo_din, 0);
`ifdef COREFIFO_WR_OVF_CNT_EN
    check("rst_ovf_count", ovf_count, 0);
`endif

    // Single write, next cycle it is presented to the FIFO
    drive(1, 'h155, 0);
    check("w1_full_pre", full, 0);
    tick();
    drive(0, 0, 0);
    check("w1_wr_en", fifo_wr_en, 1);
    check("w1_din", fifo_din, 'h155);
    check("w1_full", full, 0);
    $display("tx single: out %0h", fifo_din);
    tick();
    check("w1_idle", fifo_wr_en, 0);

    // afull follows fifo_afull while the buffer itself is empty
    fifo_afull = 1'b1; #1;
    check("afull_pass", afull, 1);
    fifo_afull = 1'b0; #1;
    check("afull_clr", afull, 0);

    // Blocked FIFO: two words buffered, third overflows
    drive(1, 'h001, 1);
    check("blk_full0", full, 0);
    tick();
    drive(1, 'h002, 1);
    check("blk_full1", full, 0);
    check("blk_wr_en", fifo_wr_en, 0);
    tick();
    drive(1, 'h003, 1);
    check("blk_full2", full, 1);
    check("blk_afull", afull, 1);
    check("blk_ovf0", overflow, 0);
    tick();
    drive(0, 0, 1);
    check("blk_ovf1", overflow, 1);
    check("blk_full3", full, 1);
    tick();
    drive(0, 0, 0);
    check("blk_ovf2", overflow, 0);
    check("blk_out1_en", fifo_wr_en, 1);
    check("blk_out1", fifo_din, 'h001);
    $display("tx blocked: out %0h", fifo_din);
    tick();
    check("blk_out2_en", fifo_wr_en, 1);
    check("blk_out2", fifo_din, 'h002);
    check("blk_full4", full, 0);
    $display("tx blocked: out %0h", fifo_din);
    tick();
    check("blk_idle", fifo_wr_en, 0);
`ifdef COREFIFO_WR_OVF_CNT_EN
    check("blk_ovf_count", ovf_count, 1);
`endif

    // Streaming 0..99 back to back
    for (int i = 0; i < 100; i++) begin
      drive(1, W'(i), 0);
      check("str_full", full, 0);
      if (i > 0) begin
        check("str_en", fifo_wr_en, 1);
        check("str_din", fifo_din, i - 1);
      end
      tick();
    end
    drive(0, 0, 0);
    check("str_last_en", fifo_wr_en, 1);
    check("str_last", fifo_din, 99);
    $display("tx stream: 100 words, last %0d", fifo_din);
    tick();
    check("str_idle", fifo_wr_en, 0);

    // fifo_full rising in ONE allows one more accept, then full
    drive(1, 'h10, 0);
    tick();
    drive(1, 'h11, 1);
    check("ff_rise_full0", full, 0);
    tick();
    drive(1, 'h12, 1);
    check("ff_rise_full1", full, 1);
    tick();

    // Reset while holding two words discards them
    reset = 1'b1;
    drive(0, 0, 0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rst_full", full, 0);
    check("mid_rst_en", fifo_wr_en, 0);
    check("mid_rst_ovf", overflow, 0);
`ifdef COREFIFO_WR_OVF_CNT_EN
    check("mid_rst_cnt", ovf_count, 0);
`endif
    drive(1, 'h3A, 0);
    tick();
    drive(0, 0, 0);
    check("post_rst_en", fifo_wr_en, 1);
    check("post_rst_din", fifo_din, 'h3A);
    $display("tx after reset: out %0h", fifo_din);
    tick();
    check("post_rst_idle", fifo_wr_en, 0);

    // Random traffic against an occupancy/queue model
    cnt = 0; rejected = 0; ovf_seen = 0; ovf_exp = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      we = ($urandom_range(0, 3) != 0);
      ff = ($urandom_range(0, 2) == 0);
      d  = W'($urandom);
      drive(we, d, ff);
      full_exp  = (cnt == 2);
      drain_exp = (cnt > 0) && !ff;
      check("rnd_full", full, full_exp);
      check("rnd_en", fifo_wr_en, drain_exp);
      check("rnd_ovf", overflow, ovf_exp);
      if (overflow === 1'b1) ovf_seen++;
      if (drain_exp) begin
        check("rnd_din", fifo_din, q[0]);
        void'(q.pop_front());
      end
      if (we && !full_exp) q.push_back(d);
      if (we && full_exp) rejected++;
      ovf_exp = we && full_exp;
      cnt = cnt + ((we && !full_exp) ? 1 : 0) - (drain_exp ? 1 : 0);
      tick();
    end
    drive(0, 0, 1);
    check("rnd_ovf_last", overflow, ovf_exp);
    if (overflow === 1'b1) ovf_seen++;
    tick();
    check("rnd_ovf_total", ovf_seen, rejected);
`ifdef COREFIFO_WR_OVF_CNT_EN
    check("rnd_ovf_count", ovf_count, rejected);
`endif
    $display("tx random: %0d rejected writes, %0d still buffered", rejected, q.size());

    // Active-high wr_en instance
    h_wr_en = 1'b1; h_din = 'h2AA;
    tick();
    h_wr_en = 1'b0; h_din = 'h111;
    #1;
    check("hi_en", h_fifo_wr_en, 1);
    check("hi_din", h_fifo_din, 'h2AA);
    $display("tx active-high: out %0h", h_fifo_din);
    tick();
    check("hi_noacc", h_fifo_wr_en, 0);
    check("hi_full", h_full, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_corefifo_wr_skid
